sysarr_load_sequencer: RTL and testbench

- Initiator side of the systolic-array load interface.
- Walks one weight tile, then one or more input/partial tiles, row by row, into sysarr_control_unit.
- Drives weight_en / input_en / partial_en / row_en, honours the control unit's fifo_has_space back-pressure, and pulls rows from the upstream scratchpad through a valid/ready handshake.
- Sits between the scratchpad read port and the control unit.

---
 rtl/sysarr_pkg.sv | 24 ++
 rtl/sysarr_row_counter.sv | 45 ++++
 rtl/sysarr_load_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_sysarr_load_sequencer.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sysarr_pkg.sv
// sysarr_pkg
// Definitions shared by the systolic-array load path:
//   - seq_state_t : load sequencer states (IDLE, LOAD_W, LOAD_IP, DONE)
//   - N, ROW_W    : array dimension and row-index width, shared with
//                   sysarr_control_unit
//   - TILE_W      : width of the tile counter
//   - SRC_WEIGHT / SRC_INPUT : scratchpad buffer select encodings
package sysarr_pkg;

  localparam int N      = 4;
  localparam int ROW_W  = $clog2(N);
  localparam int TILE_W = 8;

  localparam logic SRC_WEIGHT = 1'b0;
  localparam logic SRC_INPUT  = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD_W  = 2'd1,
    LOAD_IP = 2'd2,
    DONE    = 2'd3
  } seq_state_t;

endpackage

// File: rtl/sysarr_row_counter.sv
// sysarr_row_counter
// Modulo-N row index counter.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   inc      : advance by one row (wraps from N-1 to 0)
//   clr      : force the counter to 0; wins over inc
//   count    : current row index
//   wrap     : high in the cycle where inc is applied to row N-1
module sysarr_row_counter #(
  parameter int N     = sysarr_pkg::N,
  parameter int ROW_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [ROW_W-1:0] count,
  output logic             wrap
);

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(N - 1);

  logic [ROW_W-1:0] count_r;

  assign count = count_r;
  assign wrap  = inc && (count_r == LAST_ROW);

  // Row index register: clear has priority, explicit wrap keeps non-power-of-two N correct
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= '0;
    end else if (clr) begin
      count_r <= '0;
    end else if (inc) begin
      if (count_r == LAST_ROW) begin
        count_r <= '0;
      end else begin
        count_r <= count_r + ROW_W'(1);
      end
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/sysarr_load_sequencer.sv
// sysarr_load_sequencer
// Initiator side of the systolic-array load interface. Walks an optional
// weight tile and then num_tiles input/partial tiles row by row from the
// scratchpad into sysarr_control_unit. Writes to the control unit coincide
// with src_ready (zero-latency handshake, no output register stage).
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   start           : begin a job (sampled only in IDLE)
//   load_weights    : with start, load a weight tile first
//   num_tiles       : with start, number of input/partial tiles
//   abort           : terminate a job in progress (no done pulse)
//   src_valid/ready : scratchpad row handshake
//   src_sel         : 0 = weight buffer, 1 = input/partial buffer
//   fifo_has_space  : control unit back-pressure for input/partial rows
//   weight_en, input_en, partial_en, row_en : control unit write strobes and row
//   busy, done      : job in progress / one-cycle completion pulse
//   tiles_left      : remaining input/partial tiles
module sysarr_load_sequencer #(
  parameter int N      = sysarr_pkg::N,
  parameter int ROW_W  = $clog2(N),
  parameter int TILE_W = sysarr_pkg::TILE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              load_weights,
  input  logic [TILE_W-1:0] num_tiles,
  input  logic              abort,
  input  logic              src_valid,
  output logic              src_ready,
  output logic              src_sel,
  input  logic              fifo_has_space,
  output logic              weight_en,
  output logic              input_en,
  output logic              partial_en,
  output logic [ROW_W-1:0]  row_en,
  output logic              busy,
  output logic              done,
  output logic [TILE_W-1:0] tiles_left
);

  import sysarr_pkg::*;

  seq_state_t        state_r;
  seq_state_t        next_state_s;
  logic [TILE_W-1:0] tiles_left_r;
  logic [ROW_W-1:0]  row_cnt_s;
  logic              row_wrap_s;
  logic              row_inc_s;
  logic              row_clr_s;
  logic              tiles_load_s;
  logic              tiles_dec_s;
  logic              tiles_clr_s;

  assign tiles_left = tiles_left_r;

  sysarr_row_counter #(
    .N     (N),
    .ROW_W (ROW_W)
  ) u_row_counter (
    .clk   (clk),
    .rst   (rst),
    .inc   (row_inc_s),
    .clr   (row_clr_s),
    .count (row_cnt_s),
    .wrap  (row_wrap_s)
  );

  // Next-state, handshake and control-unit strobes
  always_comb begin
    next_state_s = state_r;
    src_ready    = 1'b0;
    src_sel      = SRC_WEIGHT;
    weight_en    = 1'b0;
    input_en     = 1'b0;
    partial_en   = 1'b0;
    row_en       = '0;
    busy         = 1'b0;
    done         = 1'b0;
    row_inc_s    = 1'b0;
    row_clr_s    = 1'b0;
    tiles_load_s = 1'b0;
    tiles_dec_s  = 1'b0;
    tiles_clr_s  = 1'b0;

    case (state_r)
      IDLE: begin
        if (start) begin
          tiles_load_s = 1'b1;
          row_clr_s    = 1'b1;
          if (load_weights) begin
            next_state_s = LOAD_W;
          end else if (num_tiles != '0) begin
            next_state_s = LOAD_IP;
          end else begin
            next_state_s = DONE;
          end
        end else begin
          next_state_s = IDLE;
        end
      end

      LOAD_W: begin
        busy    = 1'b1;
        src_sel = SRC_WEIGHT;
        row_en  = row_cnt_s;
        // Weights bypass the control unit FIFOs, so back-pressure is ignored.
        if (src_valid) begin
          src_ready = 1'b1;
          weight_en = 1'b1;
          row_inc_s = 1'b1;
        end else begin
          row_inc_s = 1'b0;
        end
        // An accept in the abort cycle still completes; only the job is dropped.
        if (abort) begin
          next_state_s = IDLE;
          row_clr_s    = 1'b1;
          tiles_clr_s  = 1'b1;
        end else if (row_wrap_s) begin
          if (tiles_left_r != '0) begin
            next_state_s = LOAD_IP;
          end else begin
            next_state_s = DONE;
          end
        end else begin
          next_state_s = LOAD_W;
        end
      end

      LOAD_IP: begin
        busy    = 1'b1;
        src_sel = SRC_INPUT;
        row_en  = row_cnt_s;
        if (src_valid && fifo_has_space) begin
          src_ready  = 1'b1;
          input_en   = 1'b1;
          partial_en = 1'b1;
          row_inc_s  = 1'b1;
        end else begin
          row_inc_s  = 1'b0;
        end
        if (abort) begin
          next_state_s = IDLE;
          row_clr_s    = 1'b1;
          tiles_clr_s  = 1'b1;
        end else if (row_wrap_s) begin
          tiles_dec_s = 1'b1;
          // Finishing when the count is about to reach zero; weights stay loaded otherwise.
          if (tiles_left_r <= TILE_W'(1)) begin
            next_state_s = DONE;
          end else begin
            next_state_s = LOAD_IP;
          end
        end else begin
          next_state_s = LOAD_IP;
        end
      end

      DONE: begin
        done         = 1'b1;
        next_state_s = IDLE;
      end

      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Remaining-tile counter; decrement saturates at zero
  always_ff @(posedge clk) begin
    if (rst) begin
      tiles_left_r <= '0;
    end else if (tiles_clr_s) begin
      tiles_left_r <= '0;
    end else if (tiles_load_s) begin
      tiles_left_r <= num_tiles;
    end else if (tiles_dec_s && (tiles_left_r != '0)) begin
      tiles_left_r <= tiles_left_r - TILE_W'(1);
    end else begin
      tiles_left_r <= tiles_left_r;
    end
  end

endmodule

// File: tb/tb_sysarr_load_sequencer.sv
// tb_sysarr_load_sequencer
// Self-checking bench for sysarr_load_sequencer. The reference model is a
// queue of expected control-unit writes (kind, row) built from the job
// parameters; each cycle the head of the queue defines what the outputs
// must be, and an accepted write pops it.
module tb_sysarr_load_sequencer;

  localparam int N      = 4;
  localparam int ROW_W  = 2;
  localparam int TILE_W = 8;
  localparam int VEC_W  = 7 + ROW_W + TILE_W;

  logic              tb_tb_clk;
  logic              rst;
  logic              start;
  logic              load_weights;
  logic [TILE_W-1:0] num_tiles;
  logic              abort;
  logic              src_valid;
  logic              src_ready;
  logic              src_sel;
  logic              fifo_has_space;
  logic              weight_en;
  logic              input_en;
  logic              partial_en;
  logic [ROW_W-1:0]  row_en;
  logic              busy;
  logic              done;
  logic [TILE_W-1:0] tiles_left;

  int pass_cnt  = 0;
  int check_cnt = 0;

  logic [VEC_W-1:0] obs;
  logic [VEC_W-1:0] zero_vec;

  sysarr_load_sequencer #(
    .N      (N),
    .ROW_W  (ROW_W),
    .TILE_W (TILE_W)
  ) dut (
    .clk            (tb_tb_clk),
    .rst            (rst),
    .start          (start),
    .load_weights   (load_weights),
    .num_tiles      (num_tiles),
    .abort          (abort),
    .src_valid      (src_valid),
    .src_ready      (src_ready),
    .src_sel        (src_sel),
    .fifo_has_space (fifo_has_space),
    .weight_en      (weight_en),
    .input_en       (input_en),
    .partial_en     (partial_en),
    .row_en         (row_en),
    .busy           (busy),
    .done           (done),
    .tiles_left     (tiles_left)
  );

  initial tb_tb_clk = 1'b0;
  always #5 tb_tb_clk = ~tb_tb_clk;

  assign obs = {busy, done, src_ready, src_sel, weight_en, input_en, partial_en, row_en, tiles_left};

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d passed=%0d", check_cnt, pass_cnt);
    $fatal(1, "watchdog expired");
  end

  // Runs one job against the write-queue model.
  // mode 0: valid/space held high; 1: random valid/space;
  // 2: space dropped 5 cycles after input row 1; 3: valid toggles 1,0,1,0...
  // abort_at: abort is raised in the cycle whose head write has this index (-1 = never).
  task automatic run_job(input bit lw, input int nt, input int mode, input int abort_at,
                         input bit junk_start, output int n_w, output int n_i, output int n_done);
    int kq[$];
    int rq[$];
    int tiles_done = 0;
    int popped = 0;
    int stall_left = 0;
    int cyc = 0;
    bit stalled_once = 1'b0;
    bit fin = 1'b0;
    bit v, s, ab, acc;
    int hk, hr;
    logic [VEC_W-1:0] expv;
    n_w = 0; n_i = 0; n_done = 0;
    if (lw) for (int r = 0; r < N; r++) begin kq.push_back(0); rq.push_back(r); end
    for (int t = 0; t < nt; t++)
      for (int r = 0; r < N; r++) begin kq.push_back(1); rq.push_back(r); end

    @(posedge tb_tb_clk); #1;
    start = 1'b1; load_weights = lw; num_tiles = TILE_W'(nt);
    abort = 1'b0; src_valid = 1'b0; fifo_has_space = 1'b0;
    @(posedge tb_tb_clk); #1;
    start = 1'b0;

    while (!fin) begin
      if (cyc >= 1000) begin
        check_cnt++;
        $display("FAIL job_timeout: %0d writes still pending, required 0", kq.size());
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        @(posedge tb_tb_clk); #1;
        rst = 1'b0;
        fin = 1'b1;
      end else if (kq.size() == 0) begin
        // Completion cycle: abort here must be ignored.
        start = 1'b0;
        abort = 1'($urandom_range(0, 1));
        src_valid = 1'($urandom_range(0, 1));
        fifo_has_space = 1'($urandom_range(0, 1));
        @(negedge tb_tb_clk);
        expv = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, {ROW_W{1'b0}}, {TILE_W{1'b0}}};
        check_cnt++;
        if (obs !== expv) $display("FAIL done_cycle: got %b required %b", obs, expv);
        else pass_cnt++;
        n_done += int'(done);
        @(posedge tb_tb_clk); #1;
        abort = 1'b0; src_valid = 1'b0; fifo_has_space = 1'b0;
        @(negedge tb_tb_clk);
        check_cnt++;
        if (obs !== zero_vec) $display("FAIL idle_after_done: got %b required %b", obs, zero_vec);
        else pass_cnt++;
        n_done += int'(done);
        fin = 1'b1;
      end else begin
        hk = kq[0];
        hr = rq[0];
        case (mode)
          0: begin v = 1'b1; s = 1'b1; end
          1: begin v = ($urandom_range(0, 3) != 0); s = ($urandom_range(0, 3) != 0); end
          2: begin
            v = 1'b1;
            s = (stall_left == 0);
            if (stall_left > 0) stall_left--;
          end
          default: begin v = (cyc % 2 == 0); s = 1'b1; end
        endcase
        ab = (popped == abort_at);
        src_valid = v; fifo_has_space = s; abort = ab;
        if (junk_start) begin
          start = 1'($urandom_range(0, 1));
          load_weights = 1'($urandom_range(0, 1));
          num_tiles = TILE_W'($urandom_range(0, 255));
        end else begin
          start = 1'b0;
        end
        @(negedge tb_tb_clk);
        acc = (hk == 0) ? v : (v && s);
        expv = {1'b1, 1'b0, acc, (hk == 1), acc && (hk == 0), acc && (hk == 1), acc && (hk == 1),
                ROW_W'(hr), TILE_W'(nt - tiles_done)};
        check_cnt++;
        if (obs !== expv) $display("FAIL load_cycle %0d (head kind %0d row %0d): got %b required %b",
                                   cyc, hk, hr, obs, expv);
        else pass_cnt++;
        n_w += int'(weight_en);
        n_i += int'(input_en);
        n_done += int'(done);
        if (acc) begin
          void'(kq.pop_front());
          void'(rq.pop_front());
          popped++;
          if (hk == 1 && hr == N - 1) tiles_done++;
          if (mode == 2 && hk == 1 && hr == 1 && !stalled_once) begin
            stall_left = 5;
            stalled_once = 1'b1;
          end
        end
        if (ab) begin
          @(posedge tb_tb_clk); #1;
          abort = 1'b0; start = 1'b0; src_valid = 1'b0; fifo_has_space = 1'b0;
          @(negedge tb_tb_clk);
          check_cnt++;
          if (obs !== zero_vec) $display("FAIL after_abort: got %b required %b", obs, zero_vec);
          else pass_cnt++;
          n_done += int'(done);
          fin = 1'b1;
        end else begin
          @(posedge tb_tb_clk); #1;
        end
      end
      cyc++;
    end
    start = 1'b0; abort = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; load_weights = 1'b1; num_tiles = 8'd3;
    abort = 1'b0; src_valid = 1'b1; fifo_has_space = 1'b1;
    repeat (2) @(posedge tb_tb_clk);
    @(negedge tb_tb_clk);
    check_cnt++;
    if (obs !== zero_vec) $display("FAIL reset_state: got %b required %b", obs, zero_vec);
    else pass_cnt++;
    #1; rst = 1'b0; start = 1'b0; src_valid = 1'b0; fifo_has_space = 1'b0;
    @(negedge tb_tb_clk);
    check_cnt++;
    if (obs !== zero_vec) $display("FAIL reset_start_ignored: got %b required %b", obs, zero_vec);
    else pass_cnt++;
  endtask

  task automatic test_weight_then_input();
    int nw, ni, nd;
    run_job(1'b1, 1, 0, -1, 1'b0, nw, ni, nd);
    check_cnt++;
    if (nw !== 4 || ni !== 4 || nd !== 1)
      $display("FAIL weight_then_input: got w=%0d i=%0d done=%0d required w=4 i=4 done=1", nw, ni, nd);
    else pass_cnt++;
  endtask

  task automatic test_input_two_tiles();
    int nw, ni, nd;
    run_job(1'b0, 2, 0, -1, 1'b0, nw, ni, nd);
    check_cnt++;
    if (nw !== 0 || ni !== 8 || nd !== 1)
      $display("FAIL input_two_tiles: got w=%0d i=%0d done=%0d required w=0 i=8 done=1", nw, ni, nd);
    else pass_cnt++;
  endtask

  task automatic test_fifo_stall();
    int nw, ni, nd;
    run_job(1'b0, 1, 2, -1, 1'b0, nw, ni, nd);
    check_cnt++;
    if (ni !== 4 || nd !== 1)
      $display("FAIL fifo_stall: got i=%0d done=%0d required i=4 done=1", ni, nd);
    else pass_cnt++;
  endtask

  task automatic test_valid_toggle();
    int nw, ni, nd;
    run_job(1'b1, 1, 3, -1, 1'b0, nw, ni, nd);
    check_cnt++;
    if (nw !== 4 || ni !== 4)
      $display("FAIL valid_toggle: got w=%0d i=%0d required w=4 i=4", nw, ni);
    else pass_cnt++;
  endtask

  task automatic test_abort();
    int nw, ni, nd;
    run_job(1'b0, 3, 0, N + 2, 1'b0, nw, ni, nd);
    check_cnt++;
    if (nd !== 0 || ni !== N + 3)
      $display("FAIL abort_job: got i=%0d done=%0d required i=%0d done=0", ni, nd, N + 3);
    else pass_cnt++;
    run_job(1'b1, 1, 0, -1, 1'b0, nw, ni, nd);
    check_cnt++;
    if (nw !== 4 || ni !== 4 || nd !== 1)
      $display("FAIL restart_after_abort: got w=%0d i=%0d done=%0d required 4/4/1", nw, ni, nd);
    else pass_cnt++;
  endtask

  task automatic test_zero_job();
    int nw, ni, nd;
    run_job(1'b0, 0, 0, -1, 1'b0, nw, ni, nd);
    check_cnt++;
    if (nw !== 0 || ni !== 0 || nd !== 1)
      $display("FAIL zero_job: got w=%0d i=%0d done=%0d required 0/0/1", nw, ni, nd);
    else pass_cnt++;
    run_job(1'b1, 0, 0, -1, 1'b0, nw, ni, nd);
    check_cnt++;
    if (nw !== 4 || ni !== 0 || nd !== 1)
      $display("FAIL weights_only: got w=%0d i=%0d done=%0d required 4/0/1", nw, ni, nd);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_load();
    int nw, ni, nd;
    @(posedge tb_tb_clk); #1;
    start = 1'b1; load_weights = 1'b0; num_tiles = 8'd2;
    src_valid = 1'b1; fifo_has_space = 1'b1;
    @(posedge tb_tb_clk); #1;
    start = 1'b0;
    repeat (5) @(posedge tb_tb_clk);
    #1; rst = 1'b1; abort = 1'b1;
    @(posedge tb_tb_clk);
    @(negedge tb_tb_clk);
    check_cnt++;
    if (obs !== zero_vec) $display("FAIL reset_mid_load: got %b required %b", obs, zero_vec);
    else pass_cnt++;
    #1; rst = 1'b0; abort = 1'b0; src_valid = 1'b0; fifo_has_space = 1'b0;
    run_job(1'b0, 1, 0, -1, 1'b0, nw, ni, nd);
    check_cnt++;
    if (ni !== 4 || nd !== 1)
      $display("FAIL recover_after_reset: got i=%0d done=%0d required 4/1", ni, nd);
    else pass_cnt++;
  endtask

  task automatic test_random();
    int nw, ni, nd, nt, total, abort_at;
    bit lw;
    for (int j = 0; j < 20; j++) begin
      lw = 1'($urandom_range(0, 1));
      nt = $urandom_range(0, 3);
      total = (lw ? N : 0) + nt * N;
      abort_at = -1;
      if (total > 0 && $urandom_range(0, 3) == 0) abort_at = $urandom_range(0, total - 1);
      run_job(lw, nt, 1, abort_at, 1'b1, nw, ni, nd);
      check_cnt++;
      if (nd !== ((abort_at < 0) ? 1 : 0))
        $display("FAIL random_job %0d done count: got %0d required %0d", j, nd, (abort_at < 0) ? 1 : 0);
      else pass_cnt++;
    end
  endtask

  initial begin
    zero_vec = '0;
    test_reset();
    test_weight_then_input();
    test_input_two_tiles();
    test_fifo_stall();
    test_valid_toggle();
    test_abort();
    test_zero_job();
    test_reset_mid_load();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
